alu_op_issuer: RTL and testbench

//  Initiator side of the Arithematic unit interface. Accepts one ALU command at a time

---
 rtl/alu_op_issuer.sv | 135 +++++++++++++
 tb/tb_alu_op_issuer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Issues one command at a time to a combinational arithmetic unit and returns
// the captured result, with divide-by-zero status, over a valid/ready response port.
module alu_op_issuer #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_a,
  input  logic [N-1:0]  cmd_b,
  input  logic [M-2:0]  cmd_op,
  input  logic          cmd_chain,
  output logic [N-1:0]  au_a,
  output logic [N-1:0]  au_b,
  output logic [M-2:0]  au_op,
  input  logic [N-1:0]  au_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic [M-2:0]  rsp_op,
  output logic          rsp_divz,
  output logic [CW-1:0] op_count,
  output logic          busy
);

  localparam logic [M-2:0] OP_DIV = (M-1)'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          w_accept;
  logic          w_rspFire;
  logic          w_divz;
  logic [N-1:0]  w_result;

  logic [N-1:0]  r_auA;
  logic [N-1:0]  r_auB;
  logic [M-2:0]  r_auOp;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_rspData;
  logic [M-2:0]  r_rspOp;
  logic          r_rspDivz;
  logic [CW-1:0] r_opCount;

  // The unit's output is undefined on divide by zero, so it is replaced by all ones.
  assign w_divz   = (r_auOp == OP_DIV) && (r_auB == '0);
  assign w_result = w_divz ? '1 : au_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_rspFire   = 1'b0;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_nextState = DRIVE;
        end
      end
      DRIVE: begin
        busy        = 1'b1;
        w_nextState = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rspFire   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand registers change only on accept so the unit's inputs never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_auA     <= '0;
      r_auB     <= '0;
      r_auOp    <= '0;
      r_acc     <= '0;
      r_rspData <= '0;
      r_rspOp   <= '0;
      r_rspDivz <= 1'b0;
      r_opCount <= '0;
    end else begin
      if (w_accept) begin
        r_auA  <= cmd_chain ? r_acc : cmd_a;
        r_auB  <= cmd_b;
        r_auOp <= cmd_op;
      end
      if (r_state == DRIVE) begin
        r_rspData <= w_result;
        r_rspOp   <= r_auOp;
        r_rspDivz <= w_divz;
        r_acc     <= w_result;
      end
      if (w_rspFire) begin
        r_opCount <= r_opCount + 1'b1;
      end
    end
  end

  assign au_a     = r_auA;
  assign au_b     = r_auB;
  assign au_op    = r_auOp;
  assign rsp_data = r_rspData;
  assign rsp_op   = r_rspOp;
  assign rsp_divz = r_rspDivz;
  assign op_count = r_opCount;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a stand-in arithmetic unit whose
// shifts/rotates move by one bit and whose divide-by-zero output is junk.
module tb_alu_op_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic [2:0] au_op;
  logic [3:0] au_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_op;
  logic       rsp_divz;
  logic [7:0] op_count;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] expCount = 8'd0;

  alu_op_issuer #(.N(4), .M(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_result(au_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_divz(rsp_divz),
    .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in unit; divide by zero returns 5 so a passthrough would be caught.
  always_comb begin
    au_result = 4'h0;
    case (au_op)
      3'd0: au_result = au_a + au_b;
      3'd1: au_result = au_a - au_b;
      3'd2: au_result = au_a * au_b;
      3'd3: au_result = (au_b == 4'h0) ? 4'h5 : au_a / au_b;
      3'd4: au_result = {au_a[2:0], 1'b0};
      3'd5: au_result = {1'b0, au_a[3:1]};
      3'd6: au_result = {au_a[2:0], au_a[3]};
      3'd7: au_result = {au_a[0], au_a[3:1]};
      default: au_result = 4'h0;
    endcase
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One full command/response transaction; stall holds rsp_ready low in RESP
  // while a stray command is offered that must not be taken.
  task automatic applyStimulus(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic chain,
                               input logic [3:0] expA, input logic [3:0] expData,
                               input logic expDivz, input int stall);
    int n;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain;
    cmd_valid = 1'b1;
    rsp_ready = (stall == 0);
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".ready"}, int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput({tag, ".driveBusy"}, int'(busy), 1);
    checkOutput({tag, ".driveCmdReady"}, int'(cmd_ready), 0);
    checkOutput({tag, ".driveRspValid"}, int'(rsp_valid), 0);
    checkOutput({tag, ".auA"}, int'(au_a), int'(expA));
    checkOutput({tag, ".auB"}, int'(au_b), int'(b));
    checkOutput({tag, ".auOp"}, int'(au_op), int'(op));
    @(posedge clk); #1;
    checkOutput({tag, ".rspValid"}, int'(rsp_valid), 1);
    checkOutput({tag, ".rspData"}, int'(rsp_data), int'(expData));
    checkOutput({tag, ".rspOp"}, int'(rsp_op), int'(op));
    checkOutput({tag, ".rspDivz"}, int'(rsp_divz), int'(expDivz));
    for (int i = 0; i < stall; i++) begin
      cmd_a = 4'hE; cmd_b = 4'h1; cmd_op = 3'd1; cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, ".stallValid"}, int'(rsp_valid), 1);
      checkOutput({tag, ".stallData"}, int'(rsp_data), int'(expData));
      checkOutput({tag, ".stallCmdReady"}, int'(cmd_ready), 0);
      checkOutput({tag, ".stallAuA"}, int'(au_a), int'(expA));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    expCount = expCount + 8'd1;
    checkOutput({tag, ".opCount"}, int'(op_count), int'(expCount));
    checkOutput({tag, ".doneValid"}, int'(rsp_valid), 0);
    checkOutput({tag, ".doneCmdReady"}, int'(cmd_ready), 1);
    checkOutput({tag, ".doneBusy"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0;
    cmd_op = 3'd0; cmd_chain = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.cmdReady", int'(cmd_ready), 1);
    checkOutput("reset.rspValid", int'(rsp_valid), 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.opCount", int'(op_count), 0);
    checkOutput("reset.auA", int'(au_a), 0);
    checkOutput("reset.rspData", int'(rsp_data), 0);
    checkOutput("reset.rspDivz", int'(rsp_divz), 0);

    applyStimulus("chainFirst", 4'h9, 4'h2, 3'd0, 1'b1, 4'h0, 4'h2, 1'b0, 0);
    applyStimulus("add",        4'h3, 4'h4, 3'd0, 1'b0, 4'h3, 4'h7, 1'b0, 0);
    applyStimulus("sub",        4'h2, 4'h5, 3'd1, 1'b0, 4'h2, 4'hD, 1'b0, 0);
    applyStimulus("mul",        4'h5, 4'h3, 3'd2, 1'b0, 4'h5, 4'hF, 1'b0, 0);
    applyStimulus("add56",      4'h5, 4'h6, 3'd0, 1'b0, 4'h5, 4'hB, 1'b0, 0);
    applyStimulus("chainShl",   4'h0, 4'h0, 3'd4, 1'b1, 4'hB, 4'h6, 1'b0, 0);
    applyStimulus("divZero",    4'h9, 4'h0, 3'd3, 1'b0, 4'h9, 4'hF, 1'b1, 0);
    applyStimulus("chainDivz",  4'h0, 4'h1, 3'd0, 1'b1, 4'hF, 4'h0, 1'b0, 0);
    applyStimulus("div",        4'h9, 4'h2, 3'd3, 1'b0, 4'h9, 4'h4, 1'b0, 0);
    applyStimulus("ror",        4'h3, 4'h0, 3'd7, 1'b0, 4'h3, 4'h9, 1'b0, 0);
    applyStimulus("stall",      4'h1, 4'h1, 3'd0, 1'b0, 4'h1, 4'h2, 1'b0, 5);

    // Reset while the command is in DRIVE discards it and clears acc/op_count.
    @(negedge clk);
    cmd_a = 4'h3; cmd_b = 4'h3; cmd_op = 3'd0; cmd_chain = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("midReset.inDrive", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expCount = 8'd0;
    checkOutput("midReset.rspValid", int'(rsp_valid), 0);
    checkOutput("midReset.opCount", int'(op_count), 0);
    checkOutput("midReset.cmdReady", int'(cmd_ready), 1);
    checkOutput("midReset.busy", int'(busy), 0);
    applyStimulus("chainAfterRst", 4'h7, 4'h3, 3'd0, 1'b1, 4'h0, 4'h3, 1'b0, 0);

    for (int i = 1; i < 256; i++) begin
      applyStimulus("wrapRun", 4'(i), 4'h1, 3'd0, 1'b0, 4'(i), 4'(i + 1), 1'b0, 0);
    end
    checkOutput("wrap.zero", int'(op_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
